round_checker: RTL and testbench
================================

Name: round_checker

Overview:
- Game-control stage directly downstream of the prompt generator (LFSR selectors plus the not/colour-logic decode).
- Each round it advances the prompt LFSRs by one step, latches the 4-bit expected answer, then waits for the player to submit a 4-bit switch answer.
- Enforces a per-round countdown, scores correct answers, decrements lives on a wrong answer or timeout, and ends the game at zero lives.
- Outputs drive the HEX score and time displays and the LED feedback.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per countdown second (benches override with a small value).
- ROUND_SECS, 5, seconds allowed per round (1..15).
- START_LIVES, 3, lives at game start (1..7).
- FEEDBACK_TICKS, 25000000, cycles the result is held before the next round.
- SCORE_W, 8, score counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level; rising edge starts a game from IDLE or GAME_OVER.
- submit  in  1  level, already debounced and active-high; rising edge submits an answer.
- player_answer  in  4  player switches, one bit per colour.
- expected_answer  in  4  combinational answer from the prompt stage.
- prompt_enable  out  1  one-cycle pulse that advances the prompt LFSRs.
- round_active  out  1  high while the player may answer.
- time_left  out  4  whole seconds remaining in the current round.
- score  out  SCORE_W  correct answers this game.
- lives  out  3  remaining lives.
- result_valid  out  1  high during FEEDBACK.
- result_correct  out  1  during FEEDBACK: 1 = correct, 0 = wrong or timeout.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- reset low at a clock edge puts the block in IDLE and clears internal counters and edge-detect history. Output values after reset:
  - prompt_enable 0, round_active 0, time_left 0
  - score 0, lives START_LIVES
  - result_valid 0, result_correct 0, game_over 0
- Edge detect:
  - start and submit are each registered once; an edge is input high while the registered copy is low.
  - A submit still held high at round entry does not count until it is released and pressed again.
- IDLE -> ADVANCE on a start edge. Score is cleared to 0 and lives set to START_LIVES on that transition.
- ADVANCE (1 cycle): prompt_enable = 1. Next state is SETTLE.
- SETTLE (1 cycle): expected_answer is latched into expected_q, since the LFSRs updated on the previous edge. The sub-second counter is cleared and time_left loads ROUND_SECS. Next state is WAIT.
- WAIT (round_active = 1):
  - The sub-second counter counts 0..TICKS_PER_SEC-1; at wrap, time_left decrements.
  - On a submit edge, compare player_answer against expected_q (all 4 bits). A match is correct; anything else is wrong. Go to FEEDBACK.
  - If time_left is 1 and the sub-second counter wraps, go to FEEDBACK as a timeout; time_left shows 0.
  - If a submit edge and the timeout occur in the same cycle, the submit wins.
- FEEDBACK (result_valid = 1), held FEEDBACK_TICKS cycles:
  - On entry, correct: score increments, saturating at all-ones.
  - On entry, wrong or timeout: lives decrements.
  - At exit, go to GAME_OVER if lives is 0, otherwise to ADVANCE.
  - Submit and start edges are ignored.
- GAME_OVER: game_over = 1. score and lives are held for display. A start edge goes to ADVANCE with score 0 and lives START_LIVES.
- A start edge in any state other than IDLE and GAME_OVER is ignored.
- reset low mid-round aborts immediately to IDLE; no prompt_enable pulse is issued.
- All outputs are registered, or decoded directly from state registers.
- Latency from submit edge to result_valid = 1 cycle after the edge-detect register.

Decomposition:
- Shared package not_not_pkg holds:
  - the state enum (IDLE, ADVANCE, SETTLE, WAIT, FEEDBACK, GAME_OVER)
  - ANSWER_W = 4
  - the LIVES_W = 3 constant
- One sub-module, second_ticker: a parameterised TICKS_PER_SEC counter with a synchronous clear input and a one-cycle tick output. The checker instantiates it for the countdown.

Test Plan (TICKS_PER_SEC=10, ROUND_SECS=3, FEEDBACK_TICKS=4, START_LIVES=3):
1. Release reset, pulse start -> prompt_enable high exactly 1 cycle; two cycles later round_active=1, time_left=3.
2. expected_answer=4'b0101, player_answer=4'b0101, submit edge -> result_valid=1 with result_correct=1 for 4 cycles; score=1, lives=3; another prompt_enable pulse follows.
3. expected_answer=4'b1010, player_answer=4'b1011, submit edge -> result_correct=0, lives=2, score unchanged.
4. No submit -> time_left steps 3,2,1,0 every 10 cycles; timeout at cycle 30 of WAIT gives result_correct=0 and lives decremented.
5. Lose 3 lives -> game_over=1, round_active=0, score held. Submit ignored. A start edge gives score=0, lives=3 and a prompt_enable pulse.
6. Submit edge in the same cycle as the timeout -> graded as a submit. Separately, reset low mid-WAIT -> next cycle IDLE, score=0, lives=3, no prompt_enable.

Source files
------------

// File: rtl/not_not_pkg.sv
// Shared types and widths for the game-control stage.
// Holds the round FSM encoding and the answer/lives widths.
package not_not_pkg;

  localparam int ANSWER_W = 4;
  localparam int LIVES_W  = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADVANCE   = 3'd1,
    SETTLE    = 3'd2,
    WAIT      = 3'd3,
    FEEDBACK  = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

endpackage

// File: rtl/round_checker_second_ticker.sv
// Free-running sub-second counter for the round countdown.
// tick is high on the last count of each second while enabled.
module second_ticker #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = enable && (cnt_reg == LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/round_checker.sv
// Round sequencing, countdown, scoring and lives for the prompt game.
// Outputs are registers or direct decodes of the state register.
module round_checker
  import not_not_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 50000000,
  parameter int ROUND_SECS     = 5,
  parameter int START_LIVES    = 3,
  parameter int FEEDBACK_TICKS = 25000000,
  parameter int SCORE_W        = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                submit,
  input  logic [ANSWER_W-1:0] player_answer,
  input  logic [ANSWER_W-1:0] expected_answer,
  output logic                prompt_enable,
  output logic                round_active,
  output logic [3:0]          time_left,
  output logic [SCORE_W-1:0]  score,
  output logic [LIVES_W-1:0]  lives,
  output logic                result_valid,
  output logic                result_correct,
  output logic                game_over
);

  localparam int FW = (FEEDBACK_TICKS > 1) ? $clog2(FEEDBACK_TICKS) : 1;
  localparam logic [FW-1:0]      FB_LAST    = FW'(FEEDBACK_TICKS - 1);
  localparam logic [3:0]         ROUND_INIT = 4'(ROUND_SECS);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

  state_t                state_reg;
  logic                  start_q_reg;
  logic                  submit_q_reg;
  logic [ANSWER_W-1:0]   expected_q_reg;
  logic [3:0]            time_left_reg;
  logic [SCORE_W-1:0]    score_reg;
  logic [LIVES_W-1:0]    lives_reg;
  logic                  correct_reg;
  logic [FW-1:0]         fb_cnt_reg;

  logic start_edge;
  logic submit_edge;
  logic sec_tick;
  logic answer_match;

  assign start_edge   = start && !start_q_reg;
  assign submit_edge  = submit && !submit_q_reg;
  assign answer_match = (player_answer == expected_q_reg);

  second_ticker #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_ticker (
    .clock (clock),
    .reset (reset),
    .clear (state_reg == SETTLE),
    .enable(state_reg == WAIT),
    .tick  (sec_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
      start_q_reg    <= 1'b0;
      submit_q_reg   <= 1'b0;
      expected_q_reg <= '0;
      time_left_reg  <= '0;
      score_reg      <= '0;
      lives_reg      <= LIVES_INIT;
      correct_reg    <= 1'b0;
      fb_cnt_reg     <= '0;
    end else begin
      start_q_reg  <= start;
      submit_q_reg <= submit;
      case (state_reg)
        IDLE, GAME_OVER: begin
          if (start_edge) begin
            state_reg <= ADVANCE;
            score_reg <= '0;
            lives_reg <= LIVES_INIT;
          end
        end
        ADVANCE: state_reg <= SETTLE;
        SETTLE: begin
          // The LFSRs moved on the previous edge, so the decode is stable now.
          expected_q_reg <= expected_answer;
          time_left_reg  <= ROUND_INIT;
          state_reg      <= WAIT;
        end
        WAIT: begin
          if (submit_edge) begin
            correct_reg <= answer_match;
            fb_cnt_reg  <= '0;
            state_reg   <= FEEDBACK;
            if (answer_match) begin
              if (!(&score_reg)) score_reg <= score_reg + 1'b1;
            end else begin
              lives_reg <= lives_reg - 1'b1;
            end
          end else if (sec_tick) begin
            time_left_reg <= time_left_reg - 1'b1;
            if (time_left_reg == 4'd1) begin
              correct_reg <= 1'b0;
              lives_reg   <= lives_reg - 1'b1;
              fb_cnt_reg  <= '0;
              state_reg   <= FEEDBACK;
            end
          end
        end
        FEEDBACK: begin
          if (fb_cnt_reg == FB_LAST) begin
            state_reg <= (lives_reg == '0) ? GAME_OVER : ADVANCE;
          end else begin
            fb_cnt_reg <= fb_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign prompt_enable  = (state_reg == ADVANCE);
  assign round_active   = (state_reg == WAIT);
  assign result_valid   = (state_reg == FEEDBACK);
  assign game_over      = (state_reg == GAME_OVER);
  assign result_correct = correct_reg;
  assign time_left      = time_left_reg;
  assign score          = score_reg;
  assign lives          = lives_reg;

endmodule

// File: tb/tb_round_checker.sv
// Self-checking bench: directed game scenarios with literal expectations,
// then randomized play checked every cycle against a behavioural game model.
module tb_round_checker;

  localparam int TPS = 10;
  localparam int RS  = 3;
  localparam int FBT = 4;
  localparam int SL  = 3;
  localparam int SW  = 8;

  localparam int M_IDLE = 0, M_ADV = 1, M_SET = 2, M_WAIT = 3, M_FB = 4, M_GO = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          submit = 1'b0;
  logic [3:0]    player_answer = 4'd0;
  logic [3:0]    expected_answer = 4'd0;
  logic          prompt_enable;
  logic          round_active;
  logic [3:0]    time_left;
  logic [SW-1:0] score;
  logic [2:0]    lives;
  logic          result_valid;
  logic          result_correct;
  logic          game_over;

  int checks = 0;
  int errors = 0;

  round_checker #(
    .TICKS_PER_SEC (TPS),
    .ROUND_SECS    (RS),
    .START_LIVES   (SL),
    .FEEDBACK_TICKS(FBT),
    .SCORE_W       (SW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .submit         (submit),
    .player_answer  (player_answer),
    .expected_answer(expected_answer),
    .prompt_enable  (prompt_enable),
    .round_active   (round_active),
    .time_left      (time_left),
    .score          (score),
    .lives          (lives),
    .result_valid   (result_valid),
    .result_correct (result_correct),
    .game_over      (game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural game model: rounds measured in elapsed cycles, not counters.
  int       m_mode = M_IDLE;
  int       m_score = 0;
  int       m_lives = SL;
  int       m_tl = 0;
  int       m_correct = 0;
  int       m_wait_n = 0;
  int       m_fb_n = 0;
  logic [3:0] m_exp = 4'd0;
  bit       m_sp = 0, m_bp = 0, m_seen_reset = 0;
  bit       st_e, sb_e;

  task automatic model_grade(input bit ok);
    m_correct = ok;
    if (ok) begin
      if (m_score < (1 << SW) - 1) m_score++;
    end else begin
      m_lives--;
    end
    m_fb_n = 0;
    m_mode = M_FB;
  endtask

  always @(posedge clock) begin
    if (!reset) begin
      m_mode = M_IDLE; m_score = 0; m_lives = SL; m_tl = 0; m_correct = 0;
      m_sp = 0; m_bp = 0; m_wait_n = 0; m_fb_n = 0; m_exp = 4'd0;
      m_seen_reset = 1;
    end else begin
      st_e = start && !m_sp;
      sb_e = submit && !m_bp;
      case (m_mode)
        M_IDLE, M_GO: if (st_e) begin m_mode = M_ADV; m_score = 0; m_lives = SL; end
        M_ADV: m_mode = M_SET;
        M_SET: begin m_exp = expected_answer; m_tl = RS; m_wait_n = 0; m_mode = M_WAIT; end
        M_WAIT: begin
          m_wait_n++;
          if (sb_e) model_grade(player_answer == m_exp);
          else if (m_wait_n == RS * TPS) begin m_tl = 0; model_grade(0); end
          else m_tl = RS - m_wait_n / TPS;
        end
        M_FB: begin
          m_fb_n++;
          if (m_fb_n == FBT) m_mode = (m_lives == 0) ? M_GO : M_ADV;
        end
        default: m_mode = M_IDLE;
      endcase
      m_sp = start;
      m_bp = submit;
    end
  end

  always @(posedge clock) begin
    #1;
    if (m_seen_reset) begin
      chk("m_prompt_enable", prompt_enable, m_mode == M_ADV);
      chk("m_round_active", round_active, m_mode == M_WAIT);
      chk("m_result_valid", result_valid, m_mode == M_FB);
      chk("m_game_over", game_over, m_mode == M_GO);
      chk("m_time_left", time_left, m_tl);
      chk("m_score", score, m_score);
      chk("m_lives", lives, m_lives);
      if (m_mode == M_FB) chk("m_result_correct", result_correct, m_correct);
    end
  end

  task automatic wait_prompt(output int fb_cycles);
    int n;
    fb_cycles = 0;
    for (n = 0; n < 60 && !prompt_enable; n++) begin
      if (result_valid) fb_cycles++;
      @(negedge clock);
    end
    if (!prompt_enable) chk("wait_prompt_timeout", 0, 1);
  endtask

  task automatic wait_round();
    int n;
    for (n = 0; n < 20 && !round_active; n++) @(negedge clock);
    if (!round_active) chk("wait_round_timeout", 0, 1);
  endtask

  initial begin
    int fbc;
    int n;
    reset = 1'b0;
    expected_answer = 4'b0101;
    repeat (3) @(negedge clock);
    chk("rst_prompt_enable", prompt_enable, 0);
    chk("rst_round_active", round_active, 0);
    chk("rst_time_left", time_left, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_correct", result_correct, 0);
    chk("rst_game_over", game_over, 0);
    reset = 1'b1;
    @(negedge clock);

    start = 1'b1;
    @(negedge clock);
    chk("start_prompt_pulse", prompt_enable, 1);
    start = 1'b0;
    @(negedge clock);
    chk("prompt_one_cycle", prompt_enable, 0);
    @(negedge clock);
    chk("round_active_on", round_active, 1);
    chk("time_left_load", time_left, 3);

    player_answer = 4'b0101;
    submit = 1'b1;
    @(negedge clock);
    $display("round 1: correct answer submitted");
    chk("r1_result_valid", result_valid, 1);
    chk("r1_result_correct", result_correct, 1);
    chk("r1_score", score, 1);
    chk("r1_lives", lives, 3);
    submit = 1'b0;
    wait_prompt(fbc);
    chk("r1_feedback_len", fbc, 4);

    expected_answer = 4'b1010;
    wait_round();
    player_answer = 4'b1011;
    submit = 1'b1;
    @(negedge clock);
    $display("round 2: wrong answer submitted");
    chk("r2_result_correct", result_correct, 0);
    chk("r2_lives", lives, 2);
    chk("r2_score", score, 1);
    submit = 1'b0;

    wait_prompt(fbc);
    wait_round();
    n = 0;
    while (round_active && n < 100) begin
      if (n == 0)  chk("r3_tl_3", time_left, 3);
      if (n == 10) chk("r3_tl_2", time_left, 2);
      if (n == 20) chk("r3_tl_1", time_left, 1);
      n++;
      @(negedge clock);
    end
    $display("round 3: timeout after %0d cycles", n);
    chk("r3_wait_cycles", n, 30);
    chk("r3_time_left_0", time_left, 0);
    chk("r3_result_correct", result_correct, 0);
    chk("r3_lives", lives, 1);

    n = 0;
    while (!game_over && n < 100) begin n++; @(negedge clock); end
    $display("round 4: timeout, game over");
    chk("go_game_over", game_over, 1);
    chk("go_round_active", round_active, 0);
    chk("go_score_held", score, 1);
    chk("go_lives", lives, 0);
    submit = 1'b1;
    repeat (2) @(negedge clock);
    chk("go_submit_ignored_score", score, 1);
    chk("go_submit_ignored_state", game_over, 1);
    submit = 1'b0;
    start = 1'b1;
    @(negedge clock);
    $display("restart from game over");
    chk("restart_prompt", prompt_enable, 1);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);
    start = 1'b0;

    player_answer = 4'b1010;
    wait_round();
    for (int i = 0; i < 29; i++) @(negedge clock);
    submit = 1'b1;
    @(negedge clock);
    $display("round 5: submit on timeout cycle");
    chk("tie_result_valid", result_valid, 1);
    chk("tie_result_correct", result_correct, 1);
    chk("tie_score", score, 1);
    chk("tie_lives", lives, 3);
    submit = 1'b0;

    wait_prompt(fbc);
    wait_round();
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("reset mid-round");
    chk("abort_round_active", round_active, 0);
    chk("abort_prompt", prompt_enable, 0);
    chk("abort_score", score, 0);
    chk("abort_lives", lives, 3);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_no_prompt", prompt_enable, 0);
    end

    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 999) != 0);
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) submit = ~submit;
      expected_answer = 4'($urandom);
      player_answer = $urandom_range(0, 1) ? m_exp : 4'($urandom);
    end
    reset = 1'b1;
    start = 1'b0;
    submit = 1'b0;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
